// File: rtl/vrased_monitor_n.sv
// vrased_monitor_n: registered VRASED monitor for the CPU bus and N_DMA DMA
// channels. Optional DMA checks: define VRASED_DMA_MON_EN.
// Ports: clk, puc_rst (sync, active high), pc, data_en, data_wr,
//   data_addr, dma_addr[16*N_DMA], dma_en[N_DMA] in;
//   reset, viol_cause[4:0], in_att out (all registered).
module vrased_monitor_n #(
  parameter logic [15:0] SMEM_BASE     = 16'hA000,
  parameter logic [15:0] SMEM_SIZE     = 16'h4000,
  parameter logic [15:0] KMEM_BASE     = 16'h6A00,
  parameter logic [15:0] KMEM_SIZE     = 16'h0040,
  parameter logic [15:0] SDATA_BASE    = 16'h0400,
  parameter logic [15:0] SDATA_SIZE    = 16'h0C00,
  parameter logic [15:0] HMAC_BASE     = 16'h0230,
  parameter logic [15:0] HMAC_SIZE     = 16'h0020,
  parameter logic [15:0] CTR_BASE      = 16'h9000,
  parameter logic [15:0] CTR_SIZE      = 16'h0020,
  parameter int          N_DMA         = 2,
  parameter int          RST_CYCLES    = 4,
  parameter logic [15:0] RESET_HANDLER = 16'h0000
) (
  input  logic                 clk,
  input  logic                 puc_rst,
  input  logic [15:0]          pc,
  input  logic                 data_en,
  input  logic                 data_wr,
  input  logic [15:0]          data_addr,
  input  logic [16*N_DMA-1:0]  dma_addr,
  input  logic [N_DMA-1:0]     dma_en,
  output logic                 reset,
  output logic [4:0]           viol_cause,
  output logic                 in_att
);

  localparam int CW = $clog2(RST_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(RST_CYCLES - 1);
  localparam logic [16:0] LAST_PC =
    {1'b0, SMEM_BASE} + {1'b0, SMEM_SIZE} - 17'd2;

  typedef enum logic {RUN, HOLD} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [15:0]   pc_prev;

  // 17-bit compare so that BASE+SIZE never wraps.
  function automatic logic in_r(
    input logic [15:0] x,
    input logic [15:0] base,
    input logic [15:0] size
  );
    logic [16:0] lo;
    logic [16:0] hi;
    lo = {1'b0, base};
    hi = {1'b0, base} + {1'b0, size};
    return ({1'b0, x} >= lo) && ({1'b0, x} < hi);
  endfunction

  logic sm_pc;
  logic sm_prev;
  logic prev_last;
  logic key_v;
  logic atom_v;
  logic xs_v;
  logic ctr_v;
  logic dma_v;
  logic legal_in;
  logic legal_out;
  logic [4:0] cause;

  always_comb begin
    sm_pc     = in_r(pc, SMEM_BASE, SMEM_SIZE);
    sm_prev   = in_r(pc_prev, SMEM_BASE, SMEM_SIZE);
    prev_last = ({1'b0, pc_prev} == LAST_PC);
    key_v = data_en && !sm_pc &&
            in_r(data_addr, KMEM_BASE, KMEM_SIZE);
    atom_v = (!sm_prev && sm_pc && pc != SMEM_BASE) ||
             (sm_prev && !sm_pc && !prev_last);
    xs_v = (sm_pc && data_wr && data_en &&
            !in_r(data_addr, SDATA_BASE, SDATA_SIZE) &&
            !in_r(data_addr, HMAC_BASE, HMAC_SIZE)) ||
           (!sm_pc && data_en &&
            in_r(data_addr, SDATA_BASE, SDATA_SIZE));
    ctr_v = data_en && data_wr && !sm_pc &&
            in_r(data_addr, CTR_BASE, CTR_SIZE);
    legal_in  = !sm_prev && pc == SMEM_BASE;
    legal_out = sm_prev && !sm_pc && prev_last;
    cause = {dma_v, ctr_v, xs_v, atom_v, key_v};
  end

`ifdef VRASED_DMA_MON_EN
  always_comb begin
    dma_v = 1'b0;
    for (int i = 0; i < N_DMA; i++) begin
      if (dma_en[i] &&
          (in_att ||
           in_r(dma_addr[16*i +: 16], KMEM_BASE, KMEM_SIZE) ||
           in_r(dma_addr[16*i +: 16], SDATA_BASE, SDATA_SIZE) ||
           in_r(dma_addr[16*i +: 16], CTR_BASE, CTR_SIZE)))
        dma_v = 1'b1;
    end
  end
`else
  logic unused_dma;
  assign unused_dma = ^{dma_en, dma_addr};
  assign dma_v = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (puc_rst) begin
      state      <= RUN;
      reset      <= 1'b0;
      viol_cause <= 5'b0;
      in_att     <= 1'b0;
      cnt        <= '0;
      pc_prev    <= RESET_HANDLER;
    end else begin
      unique case (state)
        RUN: begin
          pc_prev <= pc;
          if (|cause) begin
            state      <= HOLD;
            reset      <= 1'b1;
            viol_cause <= cause;
            in_att     <= 1'b0;
            cnt        <= CNT_LOAD;
          end else if (legal_in) begin
            in_att <= 1'b1;
          end else if (legal_out) begin
            in_att <= 1'b0;
          end
        end
        HOLD: begin
          pc_prev <= RESET_HANDLER;
          if (cnt == '0) begin
            state <= RUN;
            reset <= 1'b0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: begin
          state <= RUN;
          reset <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vrased_monitor_n.sv
// tb_vrased_monitor_n: directed + randomized bench for vrased_monitor_n,
// checked against an address-rule reference model.
module tb_vrased_monitor_n;

  localparam int RST = 4;

  logic        clk = 1'b0;
  logic        puc_rst;
  logic [15:0] pc;
  logic        data_en;
  logic        data_wr;
  logic [15:0] data_addr;
  logic [31:0] dma_addr;
  logic [1:0]  dma_en;
  logic        reset;
  logic [4:0]  viol_cause;
  logic        in_att;

  int n_vec = 0;
  int n_err = 0;

  // reference model state
  bit       m_reset;
  bit [4:0] m_cause;
  bit       m_att;
  int       m_hold;
  int       m_prev;

  vrased_monitor_n dut (
    .clk(clk), .puc_rst(puc_rst), .pc(pc),
    .data_en(data_en), .data_wr(data_wr),
    .data_addr(data_addr), .dma_addr(dma_addr),
    .dma_en(dma_en), .reset(reset),
    .viol_cause(viol_cause), .in_att(in_att)
  );

  always #5 clk = ~clk;

  function automatic bit inr(int x, int b, int s);
    return x >= b && x < b + s;
  endfunction

  function automatic bit sm(int x);
    return inr(x, 'hA000, 'h4000);
  endfunction

  function automatic bit [4:0] mcause();
    int p;
    int a;
    bit [4:0] c;
    p = pc;
    a = data_addr;
    c = '0;
    c[0] = data_en && inr(a, 'h6A00, 'h40) && !sm(p);
    c[1] = (!sm(m_prev) && sm(p) && p != 'hA000) ||
           (sm(m_prev) && !sm(p) && m_prev != 'hDFFE);
    c[2] = (sm(p) && data_wr && data_en &&
            !inr(a, 'h400, 'hC00) && !inr(a, 'h230, 'h20)) ||
           (!sm(p) && data_en && inr(a, 'h400, 'hC00));
    c[3] = data_en && data_wr && inr(a, 'h9000, 'h20) && !sm(p);
`ifdef VRASED_DMA_MON_EN
    for (int i = 0; i < 2; i++) begin
      int d;
      d = dma_addr[16*i +: 16];
      if (dma_en[i] && (m_att || inr(d, 'h6A00, 'h40) ||
          inr(d, 'h400, 'hC00) || inr(d, 'h9000, 'h20)))
        c[4] = 1'b1;
    end
`endif
    return c;
  endfunction

  function automatic void model_step();
    bit [4:0] c;
    if (puc_rst) begin
      m_hold = 0; m_cause = 0; m_att = 0; m_prev = 0;
    end else if (m_hold > 0) begin
      m_hold--;
      m_prev = 0;
    end else begin
      c = mcause();
      if (c != 0) begin
        m_cause = c; m_hold = RST; m_att = 0;
      end else if (!sm(m_prev) && pc == 16'hA000) begin
        m_att = 1;
      end else if (sm(m_prev) && !sm(pc) && m_prev == 'hDFFE) begin
        m_att = 0;
      end
      m_prev = pc;
    end
    m_reset = m_hold > 0;
  endfunction

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle(int n);
    data_en = 0; data_wr = 0; dma_en = 0; pc = 16'h8000;
    repeat (n) cycle();
  endtask

  task automatic test_reset();
    puc_rst = 1; pc = 16'h8000; data_en = 0; data_wr = 0;
    data_addr = 0; dma_addr = 0; dma_en = 0;
    cycle(); cycle();
    puc_rst = 0;
    n_vec++;
    if ({reset, viol_cause, in_att} !== 7'b0) begin
      n_err++;
      $display("FAIL reset_state got %b%b%b want 0",
               reset, viol_cause, in_att);
    end
    cycle();
  endtask

  task automatic test_key();
    pc = 16'hE000; data_en = 1; data_addr = 16'h6A10;
    cycle();
    data_en = 0;
    n_vec++;
    if (viol_cause !== 5'b00001) begin
      n_err++;
      $display("FAIL key_cause got %b want 00001", viol_cause);
    end
    for (int i = 1; i <= 5; i++) begin
      if (i > 1) cycle();
      n_vec++;
      if (reset !== (i <= RST)) begin
        n_err++;
        $display("FAIL key_reset t+%0d got %b want %b",
                 i, reset, i <= RST);
      end
    end
  endtask

  task automatic test_entry_exit();
    pc = 16'h8000; cycle();
    pc = 16'hA010; cycle();
    n_vec++;
    if (reset !== 1 || viol_cause !== 5'b00010) begin
      n_err++;
      $display("FAIL bad_entry got %b/%b want 1/00010",
               reset, viol_cause);
    end
    idle(RST + 1);
    pc = 16'hA000; cycle();
    n_vec++;
    if (reset !== 0 || in_att !== 1) begin
      n_err++;
      $display("FAIL good_entry got rst %b att %b want 0 1",
               reset, in_att);
    end
    pc = 16'hC000; cycle();
    pc = 16'h8000; cycle();
    n_vec++;
    if (viol_cause !== 5'b00010 || in_att !== 0 || reset !== 1) begin
      n_err++;
      $display("FAIL bad_exit got %b/%b/%b want 00010/0/1",
               viol_cause, in_att, reset);
    end
    idle(RST + 1);
    pc = 16'hA000; cycle();
    pc = 16'hDFFE; cycle();
    pc = 16'h8000; cycle();
    n_vec++;
    if (reset !== 0 || in_att !== 0) begin
      n_err++;
      $display("FAIL good_exit got rst %b att %b want 0 0",
               reset, in_att);
    end
  endtask

  task automatic test_dma();
    pc = 16'h8000;
    dma_en = 2'b10; dma_addr = 32'h6A00_0000;
    cycle();
    dma_en = 0;
    n_vec++;
`ifdef VRASED_DMA_MON_EN
    if (reset !== 1 || viol_cause !== 5'b10000) begin
      n_err++;
      $display("FAIL dma got %b/%b want 1/10000",
               reset, viol_cause);
    end
`else
    if (reset !== 0) begin
      n_err++;
      $display("FAIL dma_off got reset %b want 0", reset);
    end
`endif
    idle(RST + 1);
  endtask

  task automatic test_simultaneous();
    logic [4:0] want;
`ifdef VRASED_DMA_MON_EN
    want = 5'b10001;
`else
    want = 5'b00001;
`endif
    pc = 16'hE000; data_en = 1; data_addr = 16'h6A20;
    dma_en = 2'b01; dma_addr = 32'h0000_6A00;
    cycle();
    n_vec++;
    if (viol_cause !== want || reset !== 1) begin
      n_err++;
      $display("FAIL simul got %b/%b want %b/1",
               viol_cause, reset, want);
    end
    // CTR writes during HOLD must not extend or alter anything
    dma_en = 0;
    for (int i = 2; i <= 6; i++) begin
      if (i <= 4) begin
        pc = 16'h8000; data_en = 1; data_wr = 1;
        data_addr = 16'h9004;
      end else begin
        data_en = 0; data_wr = 0;
      end
      cycle();
      n_vec++;
      if (reset !== (i <= RST) || viol_cause !== want) begin
        n_err++;
        $display("FAIL hold_ctr t+%0d got %b/%b want %b/%b",
                 i, reset, viol_cause, i <= RST, want);
      end
    end
  endtask

  task automatic test_reset_mid_hold();
    pc = 16'h8000; data_en = 1; data_wr = 1;
    data_addr = 16'h9010;
    cycle();
    data_en = 0; data_wr = 0;
    cycle();
    puc_rst = 1;
    cycle();
    puc_rst = 0;
    n_vec++;
    if ({reset, viol_cause, in_att} !== 7'b0) begin
      n_err++;
      $display("FAIL mid_hold_rst got %b/%b/%b want 0",
               reset, viol_cause, in_att);
    end
  endtask

  task automatic test_random();
    logic [15:0] pcs [8];
    logic [15:0] ads [14];
    pcs = '{16'h8000, 16'h9FFE, 16'hA000, 16'hA002,
            16'hC000, 16'hDFFE, 16'hE000, 16'h0000};
    ads = '{16'h6A00, 16'h6A3E, 16'h6A40, 16'h0400,
            16'h0FFE, 16'h1000, 16'h0230, 16'h024E,
            16'h0250, 16'h9000, 16'h901E, 16'h9020,
            16'h03FE, 16'h5000};
    for (int n = 0; n < 600; n++) begin
      puc_rst   = ($urandom_range(0, 39) == 0);
      pc        = pcs[$urandom_range(0, 7)];
      data_en   = ($urandom_range(0, 2) == 0);
      data_wr   = $urandom_range(0, 1);
      data_addr = ads[$urandom_range(0, 13)];
      dma_en    = ($urandom_range(0, 5) == 0) ?
                  2'($urandom_range(1, 3)) : 2'b00;
      dma_addr  = {ads[$urandom_range(0, 13)],
                   ads[$urandom_range(0, 13)]};
      cycle();
      n_vec++;
      if (reset !== m_reset || viol_cause !== m_cause ||
          in_att !== m_att) begin
        n_err++;
        $display("FAIL random #%0d got %b/%b/%b want %b/%b/%b",
                 n, reset, viol_cause, in_att,
                 m_reset, m_cause, m_att);
      end
    end
    puc_rst = 0;
  endtask

  initial begin
    test_reset();
    test_key();
    test_entry_exit();
    test_dma();
    test_simultaneous();
    test_reset_mid_hold();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
